// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants and padder state encoding.
package sha1_pkg;

  localparam logic [31:0]  SHA1_PAD_WORD        = 32'h8000_0000;
  localparam int unsigned  SHA1_WORDS_PER_BLOCK = 16;
  localparam int unsigned  SHA1_IDX_W           = $clog2(SHA1_WORDS_PER_BLOCK);
  // Last index that can hold pad/zero words before the two length words.
  localparam logic [SHA1_IDX_W-1:0] SHA1_PRE_LEN_IDX = SHA1_IDX_W'(SHA1_WORDS_PER_BLOCK - 3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_ZERO,
    ST_LEN_HI,
    ST_LEN_LO
  } sha1_pad_state_e;

endpackage

// File: rtl/sha1_byte_pad.sv
// Masks bytes at and beyond nbytes of a big-endian word and inserts the 0x80 pad byte.
module sha1_byte_pad
  import sha1_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] padded_c
);

  always_comb begin
    padded_c = data;
    case (nbytes)
      3'd0:    padded_c = SHA1_PAD_WORD;
      3'd1:    padded_c = {data[31:24], 24'h80_0000};
      3'd2:    padded_c = {data[31:16], 16'h8000};
      3'd3:    padded_c = {data[31:8],  8'h80};
      default: padded_c = data;
    endcase
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// Streams message words into padded 512-bit SHA-1 blocks (pad byte, zero fill, 64-bit length).
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_msg_end,
  output logic        busy
);

  sha1_pad_state_e        state_q, state_d, after_pad;
  logic                   pad_pend_q, pad_pend_d;
  logic                   ready_en_q;
  logic                   adv, accept, last_full;
  logic [2:0]             nb_eff;
  logic [5:0]             add_bits;
  logic [31:0]            padded_c;
  logic                   ld, ld_end;
  logic [31:0]            ld_data;
  logic [SHA1_IDX_W-1:0]  widx_q;
  logic [LEN_W-1:0]       cnt_q, cnt_d;

  // Output slot can take a new word this cycle.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = ready_en_q && adv;
  assign accept    = in_valid && in_ready;
  assign nb_eff    = in_last ? in_nbytes : 3'd4;
  assign last_full = nb_eff >= 3'd4;
  assign add_bits  = last_full ? 6'd32 : {nb_eff, 3'b000};
  assign after_pad = (widx_q == SHA1_PRE_LEN_IDX) ? ST_LEN_HI : ST_ZERO;

  sha1_byte_pad u_byte_pad (
    .data     (in_data),
    .nbytes   (nb_eff),
    .padded_c (padded_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pad_pend_q <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pad_pend_q <= pad_pend_d;
      ready_en_q <= ((state_d == ST_IDLE) || (state_d == ST_DATA)) && !pad_pend_d;
    end
  end

  // A full final word leaves the pad word pending for the next output slot.
  always_comb begin
    state_d    = state_q;
    pad_pend_d = pad_pend_q;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (pad_pend_q) begin
          if (adv) begin
            pad_pend_d = 1'b0;
            state_d    = after_pad;
          end
        end else if (accept) begin
          state_d = ST_DATA;
          if (in_last) begin
            if (last_full) pad_pend_d = 1'b1;
            else           state_d    = after_pad;
          end
        end
      end
      ST_ZERO:   if (adv) state_d = after_pad;
      ST_LEN_HI: if (adv) state_d = ST_LEN_LO;
      ST_LEN_LO: if (adv) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld      = 1'b0;
    ld_data = '0;
    ld_end  = 1'b0;
    cnt_d   = cnt_q;
    if (accept) cnt_d = ((state_q == ST_IDLE) ? '0 : cnt_q) + LEN_W'(add_bits);
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (pad_pend_q) begin
          ld      = adv;
          ld_data = SHA1_PAD_WORD;
        end else begin
          ld      = accept;
          ld_data = padded_c;
        end
      end
      ST_ZERO:   ld = adv;
      ST_LEN_HI: begin
        ld      = adv;
        ld_data = cnt_q[LEN_W-1 -: 32];
      end
      ST_LEN_LO: begin
        ld      = adv;
        ld_data = cnt_q[31:0];
        ld_end  = 1'b1;
      end
      default: ld = 1'b0;
    endcase
  end

  // Output word register, running block index and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_msg_end <= 1'b0;
      busy        <= 1'b0;
      widx_q      <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (ld) begin
        out_valid   <= 1'b1;
        out_data    <= ld_data;
        out_idx     <= widx_q;
        out_msg_end <= ld_end;
        widx_q      <= widx_q + SHA1_IDX_W'(1);
      end else if (out_ready) begin
        out_valid   <= 1'b0;
        out_msg_end <= 1'b0;
      end
      if (accept)                                    busy <= 1'b1;
      else if (out_valid && out_ready && out_msg_end) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Scoreboard bench for sha1_msg_padder: byte-level SHA-1 padding model vs streamed output.
module tb_sha1_msg_padder;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic [2:0]  in_nbytes;
  logic        out_valid, out_ready, out_msg_end, busy;
  logic [31:0] out_data;
  logic [3:0]  out_idx;

  exp_t         exp_q[$];
  byte unsigned msg[$];
  int           errors = 0;
  int           checks = 0;
  int           rdy_mode = 0;
  logic [3:0]   exp_idx = 4'd0;
  logic         acc_s = 1'b0;

  always #5 clk = ~clk;

  sha1_msg_padder #(.LEN_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_nbytes   (in_nbytes),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_msg_end (out_msg_end),
    .busy        (busy)
  );

  // One clock: sample handshakes at negedge, score transfers, then update out_ready after posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc_s = in_valid && in_ready;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_word: got data=%08h idx=%0d end=%0b, required no output", out_data, out_idx, out_msg_end);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_idx !== e.idx || out_msg_end !== e.last) begin
          errors++;
          $display("FAIL out_word: got data=%08h idx=%0d end=%0b, required data=%08h idx=%0d end=%0b",
                   out_data, out_idx, out_msg_end, e.data, e.idx, e.last);
        end
      end
    end
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  // Reference SHA-1 padding of msg, pushed as expected words.
  task automatic push_expected();
    byte unsigned p[$];
    logic [63:0]  bl;
    exp_t         e;
    int           nw;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nw = p.size() / 4;
    for (int w = 0; w < nw; w++) begin
      e.data = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
      e.idx  = exp_idx;
      e.last = (w == nw - 1);
      exp_q.push_back(e);
      exp_idx++;
    end
  endtask

  // Drive msg as words; if stall_at >= 0, hold out_ready low for 5 cycles after that word.
  task automatic send_msg(input int stall_at);
    int          nw, nb, n;
    logic [31:0] w;
    logic [3:0]  base;
    base = exp_idx;
    push_expected();
    nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) w = {w[23:0], ((4*k + j) < msg.size()) ? msg[4*k + j] : 8'hEE};
      nb = msg.size() - 4*k;
      if (nb > 4) nb = 4;
      in_valid  = 1'b1;
      in_data   = w;
      in_last   = (k == nw - 1);
      in_nbytes = (k == nw - 1) ? 3'(nb) : 3'($urandom_range(0, 4));
      if (k == stall_at) rdy_mode = 2;
      n = 0;
      do begin
        cycle();
        n++;
      end while (!acc_s && n < 2000);
      checks++;
      if (!acc_s) begin
        errors++;
        $display("FAIL accept_timeout: word %0d got no acceptance in %0d cycles, required acceptance", k, n);
        in_valid = 1'b0;
        return;
      end
      if (k == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          cycle();
          checks++;
          if (acc_s !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== w || out_idx !== 4'(base + k)) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got acc=%0b in_ready=%0b valid=%0b data=%08h idx=%0d, required acc=0 in_ready=0 valid=1 data=%08h idx=%0d",
                     s, acc_s, in_ready, out_valid, out_data, out_idx, w, 4'(base + k));
          end
        end
        rdy_mode = 0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; in_nbytes = 3'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || out_msg_end !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%0b in_ready=%0b busy=%0b end=%0b, required all 0", out_valid, in_ready, busy, out_msg_end);
    end
    checks++;
    if (out_data !== 32'h0 || out_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%08h idx=%0d, required 0/0", out_data, out_idx);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got in_ready=%0b, required 1", in_ready);
    end
  endtask

  task automatic test_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    send_msg(-1);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abc_pad_phase: got busy=%0b in_ready=%0b, required busy=1 in_ready=0", busy, in_ready);
    end
    wait_drain();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abc_busy_end: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_empty();
    msg.delete();
    send_msg(-1);
    wait_drain();
  endtask

  task automatic test_55();
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'(i + 1));
    send_msg(-1);
    wait_drain();
  endtask

  task automatic test_56();
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'(8'hA0 + i));
    send_msg(-1);
    wait_drain();
  endtask

  task automatic test_stall();
    msg.delete();
    for (int i = 0; i < 40; i++) msg.push_back(8'($urandom));
    send_msg(4);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    logic [31:0] w;
    int          n;
    rdy_mode = 0;
    for (int k = 0; k < 7; k++) begin
      w = $urandom;
      e.data = w; e.idx = exp_idx; e.last = 1'b0;
      exp_q.push_back(e);
      exp_idx++;
      in_valid = 1'b1; in_data = w; in_last = 1'b0; in_nbytes = 3'($urandom_range(0, 4));
      n = 0;
      do begin
        cycle();
        n++;
      end while (!acc_s && n < 2000);
      checks++;
      if (!acc_s) begin
        errors++;
        $display("FAIL mid_accept_timeout: word %0d got no acceptance, required acceptance", k);
      end
    end
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || out_msg_end !== 1'b0 ||
        out_data !== 32'h0 || out_idx !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b in_ready=%0b busy=%0b end=%0b data=%08h idx=%0d, required all 0",
               out_valid, in_ready, busy, out_msg_end, out_data, out_idx);
    end
    exp_q.delete();
    exp_idx = 4'd0;
    repeat (2) cycle();
    reset = 1'b0;
    test_abc();
  endtask

  task automatic test_back_to_back();
    int lens[7] = '{1, 4, 63, 64, 0, 119, 5};
    rdy_mode = 1;
    foreach (lens[m]) begin
      msg.delete();
      for (int i = 0; i < lens[m]; i++) msg.push_back(8'($urandom));
      send_msg(-1);
    end
    wait_drain();
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_55();
    test_56();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
